// File: rtl/change_dispenser_if.sv
// Change dispenser bus: request handshake, hopper status, eject lines and
// payout status. The master side is the vending controller / hopper
// wiring, the slave side is the change dispenser itself.
interface change_dispenser_if #(
    parameter int AMT_W = 8
) ();
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             empty5;
    logic             empty2;
    logic             empty1;
    logic             eject5;
    logic             eject2;
    logic             eject1;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] dispensed;
    logic             done;
    logic             short;

    modport master (
        output req_valid,
        output req_amount,
        input  req_ready,
        output empty5,
        output empty2,
        output empty1,
        input  eject5,
        input  eject2,
        input  eject1,
        input  remaining,
        input  dispensed,
        input  done,
        input  short
    );

    modport slave (
        input  req_valid,
        input  req_amount,
        output req_ready,
        input  empty5,
        input  empty2,
        input  empty1,
        output eject5,
        output eject2,
        output eject1,
        output remaining,
        output dispensed,
        output done,
        output short
    );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: accepts one change amount and pays it out greedily with
// 5, 2 and 1 zl coins, one coin at a time, pulsing the matching hopper
// eject line. Empty hoppers are skipped; if the amount cannot be covered
// the request ends with short set and the unpaid part left in remaining.
module change_dispenser #(
    parameter int AMT_W        = 8,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              reset,
    change_dispenser_if.slave bus
);

    // Counter must hold the larger of the two phase lengths minus one.
    localparam int MAX_PHASE = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        PULSE  = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       eject_reg;      // {5 zl, 2 zl, 1 zl}, one-hot or zero
    logic [AMT_W-1:0] coin_reg;       // value of the coin currently in flight
    logic [AMT_W-1:0] remaining_reg;
    logic [AMT_W-1:0] dispensed_reg;
    logic             done_reg;
    logic             short_reg;

    // Per-denomination view, index 0 = 1 zl, 1 = 2 zl, 2 = 5 zl.
    logic [2:0]       empty_vec;
    logic [2:0]       eligible;
    logic [2:0]       pick_onehot;
    logic [AMT_W-1:0] pick_value;

    assign empty_vec = {bus.empty5, bus.empty2, bus.empty1};

    // A denomination is usable when its hopper has coins and it fits in
    // what is still owed, so the later subtraction can never underflow.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_denom
            localparam logic [AMT_W-1:0] DENOM_VAL =
                (gi == 2) ? AMT_W'(5) : (gi == 1) ? AMT_W'(2) : AMT_W'(1);
            assign eligible[gi] = !empty_vec[gi] && (remaining_reg >= DENOM_VAL);
        end
    endgenerate

    // Greedy choice: largest eligible denomination wins.
    always_comb begin
        pick_onehot = 3'b000;
        pick_value  = '0;
        if (eligible[2]) begin
            pick_onehot = 3'b100;
            pick_value  = AMT_W'(5);
        end else if (eligible[1]) begin
            pick_onehot = 3'b010;
            pick_value  = AMT_W'(2);
        end else if (eligible[0]) begin
            pick_onehot = 3'b001;
            pick_value  = AMT_W'(1);
        end
    end

    // Payout sequencer: select coin, hold eject for the pulse time, then a
    // quiet gap before re-evaluating the greedy choice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            eject_reg     <= 3'b000;
            coin_reg      <= '0;
            remaining_reg <= '0;
            dispensed_reg <= '0;
            done_reg      <= 1'b0;
            short_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        remaining_reg <= bus.req_amount;
                        dispensed_reg <= '0;
                        short_reg     <= 1'b0;
                        state_reg     <= SELECT;
                    end
                end

                SELECT: begin
                    if (remaining_reg == '0) begin
                        short_reg <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else if (pick_onehot == 3'b000) begin
                        // Something is owed but no hopper can cover it.
                        short_reg <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        eject_reg <= pick_onehot;
                        coin_reg  <= pick_value;
                        cnt_reg   <= PULSE_LOAD;
                        state_reg <= PULSE;
                    end
                end

                PULSE: begin
                    if (cnt_reg == '0) begin
                        eject_reg     <= 3'b000;
                        remaining_reg <= remaining_reg - coin_reg;
                        dispensed_reg <= dispensed_reg + coin_reg;
                        cnt_reg       <= GAP_LOAD;
                        state_reg     <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                GAP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= SELECT;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                    eject_reg <= 3'b000;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.eject5    = eject_reg[2];
    assign bus.eject2    = eject_reg[1];
    assign bus.eject1    = eject_reg[0];
    assign bus.remaining = remaining_reg;
    assign bus.dispensed = dispensed_reg;
    assign bus.done      = done_reg;
    assign bus.short     = short_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a table of directed requests with hand-worked
// coin counts and latencies, plus hand-written sequences for reset during a
// pulse and a request held while the block is busy.
module tb_change_dispenser;

    localparam int AMT_W  = 8;
    localparam int PULSE  = 4;
    localparam int GAP    = 4;
    localparam int BUDGET = 1000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    change_dispenser_if #(.AMT_W(AMT_W)) bus ();

    change_dispenser #(
        .AMT_W(AMT_W),
        .PULSE_CYCLES(PULSE),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int fails   = 0;
    int vectors = 0;
    int rise5   = 0;
    int rise2   = 0;
    int rise1   = 0;

    typedef struct {
        logic [7:0] amt;
        logic [2:0] emp;   // {empty5, empty2, empty1}
        int         n5;
        int         n2;
        int         n1;
        int         disp;
        int         rem;
        int         shrt;
        int         lat;   // cycles from accept edge to the done cycle
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Eject line monitor: one-hot, pulse width and coin counting.
    logic [2:0] prev_ej = 3'b000;
    int         run_len = 0;
    always @(negedge clk) begin
        logic [2:0] ej;
        ej = {bus.eject5, bus.eject2, bus.eject1};
        checks++;
        if ($countones(ej) > 1) begin
            fails++;
            $display("FAIL onehot: eject=%b", ej);
        end
        if (reset) begin
            run_len = 0;
            prev_ej = 3'b000;
        end else begin
            if (ej[2] && !prev_ej[2]) rise5++;
            if (ej[1] && !prev_ej[1]) rise2++;
            if (ej[0] && !prev_ej[0]) rise1++;
            if (ej != 3'b000) begin
                run_len++;
            end else if (run_len != 0) begin
                check("pulse_width", run_len, PULSE);
                run_len = 0;
            end
            prev_ej = ej;
        end
    end

    // Wait for done, counting cycles from the accept edge; bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
            if (lat >= BUDGET) begin
                checks++;
                fails++;
                $display("FAIL timeout: no done after %0d cycles, expected done", lat);
                break;
            end
        end
    endtask

    // Present one request, release it after acceptance, wait for done.
    task automatic run_req(input logic [7:0] amt, input logic [2:0] emp,
                           output int lat, output int n5, output int n2, output int n1);
        int b5, b2, b1;
        @(negedge clk);
        bus.empty5 = emp[2];
        bus.empty2 = emp[1];
        bus.empty1 = emp[0];
        check("ready_before_req", int'(bus.req_ready), 1);
        bus.req_valid  = 1'b1;
        bus.req_amount = amt;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_amount = '0;
        b5 = rise5;
        b2 = rise2;
        b1 = rise1;
        wait_done(lat);
        n5 = rise5 - b5;
        n2 = rise2 - b2;
        n1 = rise1 - b1;
    endtask

    initial begin
        int lat, n5, n2, n1, b5, b2, b1;

        vecs[0]  = '{8'd7,   3'b000, 1,  1, 0, 7,   0, 0, 20};
        vecs[1]  = '{8'd0,   3'b000, 0,  0, 0, 0,   0, 0, 2};
        vecs[2]  = '{8'd8,   3'b100, 0,  4, 0, 8,   0, 0, 38};
        vecs[3]  = '{8'd3,   3'b011, 0,  0, 0, 0,   3, 1, 2};
        vecs[4]  = '{8'd13,  3'b000, 2,  1, 1, 13,  0, 0, 38};
        vecs[5]  = '{8'd4,   3'b010, 0,  0, 4, 4,   0, 0, 38};
        vecs[6]  = '{8'd9,   3'b001, 1,  2, 0, 9,   0, 0, 29};
        vecs[7]  = '{8'd8,   3'b001, 1,  1, 0, 7,   1, 1, 20};
        vecs[8]  = '{8'd1,   3'b111, 0,  0, 0, 0,   1, 1, 2};
        vecs[9]  = '{8'd6,   3'b000, 1,  0, 1, 6,   0, 0, 20};
        vecs[10] = '{8'd255, 3'b000, 51, 0, 0, 255, 0, 0, 461};

        bus.req_valid  = 1'b0;
        bus.req_amount = '0;
        bus.empty5     = 1'b0;
        bus.empty2     = 1'b0;
        bus.empty1     = 1'b0;

        // Reset state.
        #3;
        check("rst_ready", int'(bus.req_ready), 1);
        check("rst_eject", int'({bus.eject5, bus.eject2, bus.eject1}), 0);
        check("rst_remaining", int'(bus.remaining), 0);
        check("rst_dispensed", int'(bus.dispensed), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_short", int'(bus.short), 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        vectors++;
        $display("reset: ready=%0d remaining=%0d dispensed=%0d", bus.req_ready, bus.remaining, bus.dispensed);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            run_req(vecs[i].amt, vecs[i].emp, lat, n5, n2, n1);
            check("latency", lat, vecs[i].lat);
            check("n5", n5, vecs[i].n5);
            check("n2", n2, vecs[i].n2);
            check("n1", n1, vecs[i].n1);
            check("dispensed", int'(bus.dispensed), vecs[i].disp);
            check("remaining", int'(bus.remaining), vecs[i].rem);
            check("short", int'(bus.short), vecs[i].shrt);
            @(negedge clk);
            check("done_one_cycle", int'(bus.done), 0);
            check("ready_after", int'(bus.req_ready), 1);
            check("hold_dispensed", int'(bus.dispensed), vecs[i].disp);
            vectors++;
            $display("vec %0d: amt=%0d emp=%b lat=%0d coins5/2/1=%0d/%0d/%0d disp=%0d rem=%0d short=%0d",
                     i, vecs[i].amt, vecs[i].emp, lat, n5, n2, n1, bus.dispensed, bus.remaining, bus.short);
        end

        // Reset during the first 5 zl pulse of a 6 zl request.
        @(negedge clk);
        bus.empty5 = 1'b0;
        bus.empty2 = 1'b0;
        bus.empty1 = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_amount = 8'd6;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_amount = '0;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.eject5) break;
            if (lat >= 20) begin
                checks++;
                fails++;
                $display("FAIL timeout: eject5 never rose, expected rise");
                break;
            end
        end
        #2 reset = 1'b1;
        #1;
        check("mid_rst_eject5", int'(bus.eject5), 0);
        check("mid_rst_ready", int'(bus.req_ready), 1);
        check("mid_rst_remaining", int'(bus.remaining), 0);
        check("mid_rst_dispensed", int'(bus.dispensed), 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        run_req(8'd1, 3'b000, lat, n5, n2, n1);
        check("post_rst_latency", lat, 11);
        check("post_rst_n1", n1, 1);
        check("post_rst_n5", n5, 0);
        check("post_rst_dispensed", int'(bus.dispensed), 1);
        vectors++;
        $display("reset mid-pulse: new req 1 -> lat=%0d n1=%0d disp=%0d", lat, n1, bus.dispensed);

        // Request held while busy: 5 accepted, 2 waits until after done.
        @(negedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_amount = 8'd5;
        @(posedge clk);
        #1;
        bus.req_amount = 8'd2;
        b5 = rise5;
        b2 = rise2;
        wait_done(lat);
        check("held_first_latency", lat, 11);
        check("held_first_n5", rise5 - b5, 1);
        check("held_first_n2", rise2 - b2, 0);
        check("held_first_dispensed", int'(bus.dispensed), 5);
        check("held_first_ready", int'(bus.req_ready), 0);
        @(negedge clk);
        check("held_idle_ready", int'(bus.req_ready), 1);
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_amount = '0;
        b2 = rise2;
        wait_done(lat);
        check("held_second_latency", lat, 11);
        check("held_second_n2", rise2 - b2, 1);
        check("held_second_dispensed", int'(bus.dispensed), 2);
        check("held_second_remaining", int'(bus.remaining), 0);
        vectors++;
        $display("held request: second payout disp=%0d lat=%0d", bus.dispensed, lat);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
